// File: rtl/rv_exec_controller_pkg.sv
// Shared types and widths for the RV32I execution controller.
// The state enum values are visible on the debug port, so they are fixed.
package rv_ctrl_pkg;

  localparam int STATE_W = 3;
  localparam int ADDR_W  = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    HALTED = 3'd3,
    DUMP   = 3'd4
  } state_e;

endpackage

// File: rtl/rv_exec_controller_if.sv
// Control/status bundle between the execution controller and the board/core side.
// The controller uses the master view; the board, core and testbench use the slave view.
interface rv_exec_if;

  logic                             run_sw;
  logic                             step_btn;
  logic                             test_sw;
  logic                             hlt;
  logic                             core_en;
  logic                             test;
  logic [rv_ctrl_pkg::ADDR_W-1:0]   test_addr;
  logic                             halted;
  logic [rv_ctrl_pkg::STATE_W-1:0]  state;
  logic [31:0]                      instr_count;

  modport master (
    input  run_sw, step_btn, test_sw, hlt,
    output core_en, test, test_addr, halted, state, instr_count
  );

  modport slave (
    output run_sw, step_btn, test_sw, hlt,
    input  core_en, test, test_addr, halted, state, instr_count
  );

endinterface

// File: rtl/rv_exec_controller_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, plus a one-clock rising-edge
// strobe taken from the synchronized value.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic sync,
  output logic rise
);

  logic meta_q, sync_q, prev_q;
  logic meta_d, sync_d, prev_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync = sync_q;
  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/rv_exec_controller.sv
// Clock-enable sequencer for the RV32I core: free-run, single-step, halt, and a
// test-mode memory sweep that dwells on each address for the seven-segment display.
module rv_exec_controller
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned       DIV       = 50_000_000,
  parameter int unsigned       DWELL     = 100_000_000,
  parameter logic [ADDR_W-1:0] ADDR_LAST = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  rv_exec_if.master   bus
);

  localparam int PRE_W   = $clog2(DIV);
  localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [PRE_W-1:0]   PRE_MAX   = PRE_W'(DIV - 1);
  localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(DWELL - 1);

  logic run_s, test_s, step_s, step_rise;
  logic run_rise_unused, test_rise_unused;

  sync_edge u_run_sync  (.clk(clk), .reset(reset), .d(bus.run_sw),   .sync(run_s),  .rise(run_rise_unused));
  sync_edge u_step_sync (.clk(clk), .reset(reset), .d(bus.step_btn), .sync(step_s), .rise(step_rise));
  sync_edge u_test_sync (.clk(clk), .reset(reset), .d(bus.test_sw),  .sync(test_s), .rise(test_rise_unused));

  state_e               state_q, state_d;
  logic                 core_en_q, core_en_d;
  logic                 test_q, test_d;
  logic                 halted_q, halted_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [PRE_W-1:0]     pre_q, pre_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [31:0]          instr_count_q, instr_count_d;

  always_comb begin
    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    state_d   = state_q;
    core_en_d = 1'b0;
    pre_d     = pre_q;
    dwell_d   = dwell_q;
    addr_d    = addr_q;

    case (state_q)
      IDLE: begin
        if      (test_s)    state_d = DUMP;
        else if (bus.hlt)   state_d = HALTED;
        else if (run_s)     state_d = RUN;
        else if (step_rise) state_d = STEP;
      end
      RUN: begin
        if      (test_s)  state_d = DUMP;
        else if (bus.hlt) state_d = HALTED;
        else if (!run_s)  state_d = IDLE;
        else if (pre_q == PRE_MAX) begin
          core_en_d = 1'b1;
          pre_d     = '0;
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      STEP: begin
        // A halt arriving with the step pulse wins: no pulse is issued.
        if      (test_s)  state_d = DUMP;
        else if (bus.hlt) state_d = HALTED;
        else begin
          core_en_d = 1'b1;
          state_d   = IDLE;
        end
      end
      HALTED: begin
        if (test_s) state_d = DUMP;
      end
      DUMP: begin
        if (!test_s) state_d = halted_q ? HALTED : IDLE;
        else if (dwell_q == DWELL_MAX) begin
          dwell_d = '0;
          addr_d  = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_W'(1);
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // The prescaler only runs inside RUN so each RUN entry starts a fresh period.
    if (state_d != RUN) pre_d = '0;
    if (state_d == DUMP && state_q != DUMP) begin
      addr_d  = '0;
      dwell_d = '0;
    end

    test_d        = (state_d == DUMP);
    halted_d      = halted_q | (state_d == HALTED);
    instr_count_d = (core_en_d && instr_count_q != 32'hFFFF_FFFF) ? instr_count_q + 32'd1
                                                                  : instr_count_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      core_en_q     <= 1'b0;
      test_q        <= 1'b0;
      halted_q      <= 1'b0;
      addr_q        <= '0;
      pre_q         <= '0;
      dwell_q       <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      core_en_q     <= core_en_d;
      test_q        <= test_d;
      halted_q      <= halted_d;
      addr_q        <= addr_d;
      pre_q         <= pre_d;
      dwell_q       <= dwell_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign bus.core_en     = core_en_q;
  assign bus.test        = test_q;
  assign bus.test_addr   = addr_q;
  assign bus.halted      = halted_q;
  assign bus.state       = state_q;
  assign bus.instr_count = instr_count_q;

endmodule

// File: tb/tb_rv_exec_controller.sv
// Directed bench for rv_exec_controller with DIV=4, DWELL=3, ADDR_LAST=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rv_exec_controller;
  import rv_ctrl_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  rv_exec_if bus ();

  rv_exec_controller #(
    .DIV       (4),
    .DWELL     (3),
    .ADDR_LAST (8'd3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.run_sw = 1'b0; bus.step_btn = 1'b0; bus.test_sw = 1'b0; bus.hlt = 1'b0;
    reset = 1'b0;
    tick(2);
    n_checks++; if (bus.core_en !== 1'b0) begin n_fail++; $display("FAIL reset_core_en: got %0b expected 0", bus.core_en); end
    n_checks++; if (bus.test !== 1'b0) begin n_fail++; $display("FAIL reset_test: got %0b expected 0", bus.test); end
    n_checks++; if (bus.test_addr !== 8'd0) begin n_fail++; $display("FAIL reset_test_addr: got %0h expected 0", bus.test_addr); end
    n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %0b expected 0", bus.halted); end
    n_checks++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", bus.state); end
    n_checks++; if (bus.instr_count !== 32'd0) begin n_fail++; $display("FAIL reset_instr_count: got %0h expected 0", bus.instr_count); end
    reset = 1'b1;
    tick(3);
    n_checks++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL post_reset_state: got %0d expected 0", bus.state); end
    n_checks++; if (bus.core_en !== 1'b0) begin n_fail++; $display("FAIL post_reset_core_en: got %0b expected 0", bus.core_en); end
  endtask

  // run_sw high for 20 clocks: RUN seen at cycle 3, pulses at 7,11,15,19, IDLE at 23.
  task automatic test_run();
    logic       exp_en;
    logic [2:0] exp_st;
    bus.run_sw = 1'b1;
    for (int i = 1; i <= 26; i++) begin
      tick();
      exp_en = (i == 7 || i == 11 || i == 15 || i == 19);
      exp_st = (i >= 3 && i <= 22) ? 3'd1 : 3'd0;
      n_checks++; if (bus.core_en !== exp_en) begin n_fail++; $display("FAIL run_core_en[%0d]: got %0b expected %0b", i, bus.core_en, exp_en); end
      n_checks++; if (bus.state !== exp_st) begin n_fail++; $display("FAIL run_state[%0d]: got %0d expected %0d", i, bus.state, exp_st); end
      if (i == 20) bus.run_sw = 1'b0;
    end
    n_checks++; if (bus.instr_count !== 32'd4) begin n_fail++; $display("FAIL run_instr_count: got %0d expected 4", bus.instr_count); end
  endtask

  // Each one-clock press: STEP at cycle 3, single pulse at cycle 4. Count continues from 4.
  task automatic test_step();
    logic       exp_en;
    logic [2:0] exp_st;
    int         pulses;
    for (int t = 0; t < 3; t++) begin
      bus.step_btn = 1'b1;
      for (int i = 1; i <= 10; i++) begin
        tick();
        if (i == 1) bus.step_btn = 1'b0;
        exp_en = (i == 4);
        exp_st = (i == 3) ? 3'd2 : 3'd0;
        n_checks++; if (bus.core_en !== exp_en) begin n_fail++; $display("FAIL step_core_en[%0d.%0d]: got %0b expected %0b", t, i, bus.core_en, exp_en); end
        n_checks++; if (bus.state !== exp_st) begin n_fail++; $display("FAIL step_state[%0d.%0d]: got %0d expected %0d", t, i, bus.state, exp_st); end
      end
    end
    n_checks++; if (bus.instr_count !== 32'd7) begin n_fail++; $display("FAIL step_instr_count: got %0d expected 7", bus.instr_count); end
    pulses = 0;
    bus.step_btn = 1'b1;
    for (int i = 0; i < 20; i++) begin tick(); if (bus.core_en === 1'b1) pulses++; end
    bus.step_btn = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); if (bus.core_en === 1'b1) pulses++; end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL step_hold_pulses: got %0d expected 1", pulses); end
    n_checks++; if (bus.instr_count !== 32'd8) begin n_fail++; $display("FAIL step_hold_instr_count: got %0d expected 8", bus.instr_count); end
  endtask

  // hlt raised for the cycle in which the prescaler sits at DIV-1 suppresses that pulse.
  task automatic test_halt();
    bit got;
    got = 1'b0;
    bus.run_sw = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (bus.core_en === 1'b1) got = 1'b1;
    end
    n_checks++; if (!got) begin n_fail++; $display("FAIL halt_first_pulse: got none expected a pulse within 20 clocks"); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++; if (bus.core_en !== 1'b0) begin n_fail++; $display("FAIL halt_gap_core_en[%0d]: got %0b expected 0", i, bus.core_en); end
    end
    bus.hlt = 1'b1;
    tick();
    n_checks++; if (bus.core_en !== 1'b0) begin n_fail++; $display("FAIL halt_due_pulse: got %0b expected 0", bus.core_en); end
    n_checks++; if (bus.state !== 3'd3) begin n_fail++; $display("FAIL halt_state: got %0d expected 3", bus.state); end
    n_checks++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag: got %0b expected 1", bus.halted); end
    bus.hlt = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i % 5 == 1) bus.step_btn = 1'b1;
      if (i % 5 == 3) bus.step_btn = 1'b0;
      n_checks++; if (bus.core_en !== 1'b0) begin n_fail++; $display("FAIL halted_core_en[%0d]: got %0b expected 0", i, bus.core_en); end
      n_checks++; if (bus.state !== 3'd3) begin n_fail++; $display("FAIL halted_state[%0d]: got %0d expected 3", i, bus.state); end
    end
    bus.run_sw = 1'b0;
    bus.step_btn = 1'b0;
    tick(4);
    n_checks++; if (bus.instr_count !== 32'd9) begin n_fail++; $display("FAIL halt_instr_count: got %0d expected 9", bus.instr_count); end
  endtask

  // DUMP from HALTED: addresses 0,1,2,3,0 for 3 clocks each from cycle 3; exit at cycle 20 with address 1.
  task automatic test_dump();
    logic [7:0] exp_addr;
    bus.test_sw = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (i >= 3) begin
        exp_addr = 8'(((i - 3) / 3) % 4);
        n_checks++; if (bus.test_addr !== exp_addr) begin n_fail++; $display("FAIL dump_addr[%0d]: got %0d expected %0d", i, bus.test_addr, exp_addr); end
        n_checks++; if (bus.test !== 1'b1) begin n_fail++; $display("FAIL dump_test[%0d]: got %0b expected 1", i, bus.test); end
        n_checks++; if (bus.state !== 3'd4) begin n_fail++; $display("FAIL dump_state[%0d]: got %0d expected 4", i, bus.state); end
        n_checks++; if (bus.core_en !== 1'b0) begin n_fail++; $display("FAIL dump_core_en[%0d]: got %0b expected 0", i, bus.core_en); end
      end
    end
    bus.test_sw = 1'b0;
    for (int i = 18; i <= 22; i++) begin
      tick();
      if (i >= 20) begin
        n_checks++; if (bus.state !== 3'd3) begin n_fail++; $display("FAIL dump_exit_state[%0d]: got %0d expected 3", i, bus.state); end
        n_checks++; if (bus.test !== 1'b0) begin n_fail++; $display("FAIL dump_exit_test[%0d]: got %0b expected 0", i, bus.test); end
        n_checks++; if (bus.test_addr !== 8'd1) begin n_fail++; $display("FAIL dump_exit_addr[%0d]: got %0d expected 1", i, bus.test_addr); end
      end
    end
  endtask

  // Asynchronous reset in the middle of a sweep, checked before the next rising edge.
  task automatic test_reset_mid_dump();
    bus.test_sw = 1'b1;
    tick(9);
    n_checks++; if (bus.test_addr !== 8'd2) begin n_fail++; $display("FAIL mid_dump_addr: got %0d expected 2", bus.test_addr); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL async_reset_state: got %0d expected 0", bus.state); end
    n_checks++; if (bus.test !== 1'b0) begin n_fail++; $display("FAIL async_reset_test: got %0b expected 0", bus.test); end
    n_checks++; if (bus.test_addr !== 8'd0) begin n_fail++; $display("FAIL async_reset_addr: got %0d expected 0", bus.test_addr); end
    n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL async_reset_halted: got %0b expected 0", bus.halted); end
    n_checks++; if (bus.instr_count !== 32'd0) begin n_fail++; $display("FAIL async_reset_count: got %0d expected 0", bus.instr_count); end
    n_checks++; if (bus.core_en !== 1'b0) begin n_fail++; $display("FAIL async_reset_core_en: got %0b expected 0", bus.core_en); end
    tick();
    reset = 1'b1;
    bus.test_sw = 1'b0;
    tick(5);
    n_checks++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL after_reset_state: got %0d expected 0", bus.state); end
  endtask

  // Counter preloaded to FFFFFFFE; three step pulses must leave it at FFFFFFFF.
  task automatic test_saturation();
    int pulses;
    force dut.instr_count_d = 32'hFFFF_FFFE;
    @(posedge clk);
    #1 release dut.instr_count_d;
    tick();
    n_checks++; if (bus.instr_count !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sat_preload: got %0h expected fffffffe", bus.instr_count); end
    pulses = 0;
    for (int t = 0; t < 3; t++) begin
      bus.step_btn = 1'b1;
      for (int i = 1; i <= 10; i++) begin
        tick();
        if (i == 1) bus.step_btn = 1'b0;
        if (bus.core_en === 1'b1) pulses++;
      end
      n_checks++; if (bus.instr_count !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_count[%0d]: got %0h expected ffffffff", t, bus.instr_count); end
    end
    n_checks++; if (pulses != 3) begin n_fail++; $display("FAIL sat_pulses: got %0d expected 3", pulses); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_step();
    test_halt();
    test_dump();
    test_reset_mid_dump();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
